// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default oversampling settings,
// common to the receiver and the transmitter on the same link.
package uart_pkg;

    localparam int NB_STATE    = 3;
    localparam int N_TICK_DEF  = 16;
    localparam int NB_TICK_DEF = 4;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector whose history flop only advances on baud ticks, so an edge is held until a tick sees it.
module uart_rx_sync (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_data,
    input  logic i_valid,
    output logic o_synced,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Line idles high, so every flop resets to 1 to avoid a false edge out of reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= i_data;
            sync_q <= meta_q;
            if (i_valid) begin
                prev_q <= sync_q;
            end
        end
    end

    assign o_synced = sync_q;
    assign o_fall   = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, start + NB_DATA + [parity] + M_STOP stop bits.
// Optional parity checking is enabled with the UART_RX_PARITY_EN macro.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int N_TICK          = N_TICK_DEF,
    parameter int NB_TICK         = NB_TICK_DEF,
    parameter int NB_BIT_CNT      = 4,
    parameter int M_STOP          = 1,
    parameter int EVEN_ODD_PARITY = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_data,
    input  logic               i_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int NB_STOP = 2;
    localparam logic [NB_TICK-1:0]    TICK_MID  = NB_TICK'(N_TICK / 2 - 1);
    localparam logic [NB_TICK-1:0]    TICK_LAST = NB_TICK'(N_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0] BIT_LAST  = NB_BIT_CNT'(NB_DATA - 1);
    localparam logic [NB_STOP-1:0]    STOP_LAST = NB_STOP'(M_STOP - 1);

`ifdef UART_RX_PARITY_EN
    localparam state_e ST_AFTER_DATA = ST_PARITY;
`else
    localparam state_e ST_AFTER_DATA = ST_STOP;
`endif

    logic synced;
    logic fall;

    state_e                  state_q,     state_d;
    logic [NB_TICK-1:0]      tick_q,      tick_d;
    logic [NB_BIT_CNT-1:0]   bit_q,       bit_d;
    logic [NB_STOP-1:0]      stop_q,      stop_d;
    logic [NB_DATA-1:0]      shift_q,     shift_d;
    logic                    ferr_acc_q,  ferr_acc_d;
    logic [NB_DATA-1:0]      data_q,      data_d;
    logic                    done_q,      done_d;
    logic                    frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                    perr_acc_q,   perr_acc_d;
    logic                    parity_err_q, parity_err_d;
    logic                    parity_exp;
`endif

    uart_rx_sync u_sync (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_synced (synced),
        .o_fall   (fall)
    );

`ifdef UART_RX_PARITY_EN
    assign parity_exp = (EVEN_ODD_PARITY != 0) ? ^shift_q : ~^shift_q;
`endif

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        ferr_acc_d  = ferr_acc_q;
        data_d      = data_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        perr_acc_d   = perr_acc_q;
        parity_err_d = parity_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid && fall) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (i_valid) begin
                    if (tick_q == TICK_MID) begin
                        // A line back high at mid start bit was a glitch, not a frame.
                        state_d    = synced ? ST_IDLE : ST_DATA;
                        tick_d     = '0;
                        bit_d      = '0;
                        ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_acc_d = 1'b0;
`endif
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_valid) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {synced, shift_q[NB_DATA-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_AFTER_DATA;
                            stop_d  = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_valid) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d     = '0;
                        perr_acc_d = (synced != parity_exp);
                        state_d    = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_valid) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d     = '0;
                        ferr_acc_d = ferr_acc_q | ~synced;
                        // Returning to idle at the stop midpoint leaves half a bit to catch a back-to-back start.
                        if (stop_q == STOP_LAST) begin
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                            data_d      = shift_q;
                            frame_err_d = ferr_acc_q | ~synced;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = perr_acc_q;
`endif
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            stop_q      <= '0;
            shift_q     <= '0;
            ferr_acc_q  <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            ferr_acc_q  <= ferr_acc_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            perr_acc_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_acc_q   <= perr_acc_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven tick-accurately on the serial line,
// expected bytes/flags are queued and a negedge monitor checks each o_rx_done pulse.
module tb_uart_rx;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_data  = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_parity_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t expQ[$];

    uart_rx dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    always #5 i_clock = ~i_clock;

    // Baud tick: one clock in three, so the DUT must hold state while i_valid is low.
    int divCnt = 0;
    always @(negedge i_clock) begin
        if (divCnt == 2) begin
            divCnt  = 0;
            i_valid = 1'b1;
        end else begin
            divCnt  = divCnt + 1;
            i_valid = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must be one clock wide and match the oldest expectation.
    logic prevDone = 1'b0;
    always @(negedge i_clock) begin
        exp_t e;
        if (o_rx_done === 1'b1) begin
            checkOutput("pulse_width", {31'd0, prevDone}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rx_data", {24'd0, o_data}, {24'd0, e.data});
                checkOutput("frame_err", {31'd0, o_frame_err}, {31'd0, e.ferr});
                checkOutput("parity_err", {31'd0, o_parity_err}, {31'd0, e.perr});
            end
        end
        prevDone = o_rx_done;
    end

    task automatic waitTicks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge i_clock);
            if (i_valid) c = c + 1;
        end
        #1;
    endtask

    task automatic sendBit(input logic b);
        i_data = b;
        waitTicks(16);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic stopVal, input logic flipPar);
        exp_t e;
        e.data = d;
        e.ferr = ~stopVal;
`ifdef UART_RX_PARITY_EN
        e.perr = flipPar;
`else
        e.perr = 1'b0;
`endif
        expQ.push_back(e);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
`ifdef UART_RX_PARITY_EN
        sendBit((^d) ^ flipPar);
`endif
        sendBit(stopVal);
        i_data = 1'b1;
    endtask

    initial begin
        int w;
        logic [7:0] abortByte;

        i_reset = 1'b1;
        i_data  = 1'b1;
        repeat (4) @(posedge i_clock);
        #1;
        checkOutput("reset_data", {24'd0, o_data}, 32'd0);
        checkOutput("reset_done", {31'd0, o_rx_done}, 32'd0);
        checkOutput("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        checkOutput("reset_perr", {31'd0, o_parity_err}, 32'd0);
        i_reset = 1'b0;
        waitTicks(32);

        $display("[TB] good frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitTicks(16);

        $display("[TB] start-bit glitch");
        i_data = 1'b0;
        waitTicks(4);
        i_data = 1'b1;
        waitTicks(48);
        checkOutput("glitch_data_held", {24'd0, o_data}, 32'h0000_00A5);

        $display("[TB] framing error then recovery");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitTicks(32);
        checkOutput("ferr_held", {31'd0, o_frame_err}, 32'd1);
        checkOutput("ferr_data_held", {24'd0, o_data}, 32'h0000_003C);
        applyStimulus(8'h81, 1'b1, 1'b0);
        waitTicks(16);
        checkOutput("ferr_cleared", {31'd0, o_frame_err}, 32'd0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity checks");
        applyStimulus(8'h03, 1'b1, 1'b1);
        waitTicks(16);
        checkOutput("perr_set", {31'd0, o_parity_err}, 32'd1);
        applyStimulus(8'h03, 1'b1, 1'b0);
        waitTicks(16);
        checkOutput("perr_clear", {31'd0, o_parity_err}, 32'd0);
`endif

        $display("[TB] reset mid-frame");
        abortByte = 8'hC3;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(abortByte[i]);
        i_data = abortByte[4];
        waitTicks(5);
        i_reset = 1'b1;
        i_data  = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        checkOutput("abort_data_reset", {24'd0, o_data}, 32'd0);
        waitTicks(48);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        waitTicks(16);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0);
        waitTicks(16);
        checkOutput("last_data", {24'd0, o_data}, 32'h0000_0055);

        w = 0;
        while (expQ.size() != 0 && w < 2000) begin
            @(posedge i_clock);
            w = w + 1;
        end
        checkOutput("frames_pending", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
